// File: rtl/ppi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ppi_pkg                                                |
// | Brief   : Shared constants and helpers for the ppi_8255_cfg PPI. |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package ppi_pkg;

  typedef enum logic [1:0] {
    PPI_A    = 2'd0,
    PPI_B    = 2'd1,
    PPI_C    = 2'd2,
    PPI_CTRL = 2'd3
  } ppi_sel_e;

  localparam int CTRL_MODE_SET_BIT = 7;
  localparam int CTRL_A_DIR_BIT    = 4;
  localparam int CTRL_CU_DIR_BIT   = 3;
  localparam int CTRL_B_DIR_BIT    = 1;
  localparam int CTRL_CL_DIR_BIT   = 0;

  // A in, B out, C upper in, C lower in.
  localparam logic [7:0] PPI_CTRL_RESET = 8'h99;

  // Only mode 0 on both groups is implemented.
  function automatic logic ppi_mode_ok(input logic [7:0] cw);
    return (cw[6:5] == 2'b00) && !cw[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppi_8255_cfg_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ppi_8255_cfg_if                                        |
// | Brief   : CPU-side strobes and register select of the PPI.       |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface ppi_8255_cfg_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] a;

  modport master (output cs_n, rd_n, wr_n, a);
  modport slave  (input  cs_n, rd_n, wr_n, a);
endinterface
`default_nettype wire

// File: rtl/ppi_strobe_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ppi_strobe_sync                                        |
// | Brief   : Multi-flop synchroniser plus edge detect, idle high.   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module ppi_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clk,
  input  wire  reset_n,
  input  wire  async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_stage_check
      $error("ppi_strobe_sync: SYNC_STAGES must be 2..4");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule
`default_nettype wire

// File: rtl/ppi_8255_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ppi_8255_cfg                                           |
// | Brief   : Mode-0 programmable peripheral interface, three ports. |
// |           Optional macro PPI_PORTC_BSR_EN enables port C bit     |
// |           set/reset through control writes with d[7]=0.          |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module ppi_8255_cfg
  import ppi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CTRL_RESET  = PPI_CTRL_RESET,
  parameter bit         RD_LIVE     = 1'b0
) (
  input  wire             clk,
  input  wire             reset_n,
  ppi_8255_cfg_if.slave   bus,
  inout  wire  [7:0]      d,
  input  wire  [7:0]      pa_in,
  input  wire  [7:0]      pb_in,
  input  wire  [7:0]      pc_in,
  output logic [7:0]      pa_out,
  output logic [7:0]      pb_out,
  output logic [7:0]      pc_out,
  output logic            pa_oe,
  output logic            pb_oe,
  output logic [7:0]      pc_oe
);

  logic cs_s, cs_rise, cs_fall;
  logic rd_s, rd_rise, rd_fall;
  logic wr_s, wr_rise, wr_fall;

  ppi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .reset_n(reset_n), .async_i(bus.cs_n),
    .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  ppi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .reset_n(reset_n), .async_i(bus.rd_n),
    .sync_o(rd_s), .rise_o(rd_rise), .fall_o(rd_fall)
  );

  ppi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .reset_n(reset_n), .async_i(bus.wr_n),
    .sync_o(wr_s), .rise_o(wr_rise), .fall_o(wr_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{cs_rise, cs_fall, rd_rise, rd_fall, wr_fall};

  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] pa_q, pa_d;
  logic [7:0] pb_q, pb_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] d_s, pa_s, pb_s, pc_s;
  ppi_sel_e   wa_q, ra_q;
  logic [7:0] rd_data_q, rd_mux_d;

  // Address and data are captured alongside the strobe so the commit uses
  // the values seen while the write was still active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_s  <= 8'h00;
      wa_q <= PPI_A;
      ra_q <= PPI_A;
      pa_s <= 8'h00;
      pb_s <= 8'h00;
      pc_s <= 8'h00;
    end else begin
      if (!wr_s && !cs_s) begin
        d_s  <= d;
        wa_q <= ppi_sel_e'(bus.a);
      end
      ra_q <= ppi_sel_e'(bus.a);
      pa_s <= pa_in;
      pb_s <= pb_in;
      pc_s <= pc_in;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    pa_d   = pa_q;
    pb_d   = pb_q;
    pc_d   = pc_q;
    if (wr_rise && !cs_s) begin
      unique case (wa_q)
        PPI_A: pa_d = d_s;
        PPI_B: pb_d = d_s;
        PPI_C: pc_d = d_s;
        PPI_CTRL: begin
          if (d_s[CTRL_MODE_SET_BIT]) begin
            if (ppi_mode_ok(d_s)) begin
              ctrl_d = d_s;
              pa_d   = 8'h00;
              pb_d   = 8'h00;
              pc_d   = 8'h00;
            end
          end else begin
`ifdef PPI_PORTC_BSR_EN
            pc_d[d_s[3:1]] = d_s[0];
`else
            pc_d = pc_q;
`endif
          end
        end
        default: ctrl_d = ctrl_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= CTRL_RESET;
      pa_q   <= 8'h00;
      pb_q   <= 8'h00;
      pc_q   <= 8'h00;
    end else begin
      ctrl_q <= ctrl_d;
      pa_q   <= pa_d;
      pb_q   <= pb_d;
      pc_q   <= pc_d;
    end
  end

  // Input ports read their pins, output ports read back their latch.
  always_comb begin
    rd_mux_d = 8'h00;
    unique case (ra_q)
      PPI_A: rd_mux_d = ctrl_q[CTRL_A_DIR_BIT] ? pa_s : pa_q;
      PPI_B: rd_mux_d = ctrl_q[CTRL_B_DIR_BIT] ? pb_s : pb_q;
      PPI_C: begin
        rd_mux_d[7:4] = ctrl_q[CTRL_CU_DIR_BIT] ? pc_s[7:4] : pc_q[7:4];
        rd_mux_d[3:0] = ctrl_q[CTRL_CL_DIR_BIT] ? pc_s[3:0] : pc_q[3:0];
      end
      PPI_CTRL: rd_mux_d = ctrl_q;
      default:  rd_mux_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= 8'h00;
    end else if (RD_LIVE || rd_s) begin
      rd_data_q <= rd_mux_d;
    end
  end

  assign d = (!bus.cs_n && !bus.rd_n && bus.wr_n) ? rd_data_q : 8'hzz;

  assign pa_out = pa_q;
  assign pb_out = pb_q;
  assign pc_out = pc_q;
  assign pa_oe  = ~ctrl_q[CTRL_A_DIR_BIT];
  assign pb_oe  = ~ctrl_q[CTRL_B_DIR_BIT];
  assign pc_oe  = {{4{~ctrl_q[CTRL_CU_DIR_BIT]}}, {4{~ctrl_q[CTRL_CL_DIR_BIT]}}};

endmodule
`default_nettype wire

// File: tb/tb_ppi_8255_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_ppi_8255_cfg                                        |
// | Brief   : Scoreboard bench for ppi_8255_cfg, directed vectors.   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_ppi_8255_cfg;

  localparam int S = 2;

  localparam int K_D    = 0;
  localparam int K_PA   = 1;
  localparam int K_PB   = 2;
  localparam int K_PC   = 3;
  localparam int K_PAOE = 4;
  localparam int K_PBOE = 5;
  localparam int K_PCOE = 6;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } chk_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] tb_d;
  logic       tb_drv;
  wire  [7:0] d;
  logic [7:0] pa_in, pb_in, pc_in;
  logic [7:0] pa_out, pb_out, pc_out, pc_oe;
  logic       pa_oe, pb_oe;
  logic       smp;
  int         total;
  int         passed;
  chk_t       chk_q[$];

  ppi_8255_cfg_if bus ();

  assign d = tb_drv ? tb_d : 8'hzz;

  ppi_8255_cfg #(.SYNC_STAGES(S), .CTRL_RESET(8'h99), .RD_LIVE(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .d(d),
    .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
    .pa_out(pa_out), .pb_out(pb_out), .pc_out(pc_out),
    .pa_oe(pa_oe), .pb_oe(pb_oe), .pc_oe(pc_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      K_D:    return d;
      K_PA:   return pa_out;
      K_PB:   return pb_out;
      K_PC:   return pc_out;
      K_PAOE: return {7'b0, pa_oe};
      K_PBOE: return {7'b0, pb_oe};
      default: return pc_oe;
    endcase
  endfunction

  // Monitor: drains pending expectations whenever the bench marks a sample point.
  always @(negedge clk) begin
    chk_t       c;
    logic [7:0] act;
    if (smp) begin
      while (chk_q.size() != 0) begin
        c   = chk_q.pop_front();
        act = observe(c.kind);
        total++;
        if (act === c.exp) passed++;
        else $display("FAIL %s: got %02h expected %02h", c.name, act, c.exp);
      end
    end
  end

  task automatic push(input int kind, input logic [7:0] exp, input string name);
    chk_t c;
    c.kind = kind; c.exp = exp; c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic sample();
    @(posedge clk); #1 smp = 1'b1;
    @(negedge clk); #1 smp = 1'b0;
  endtask

  task automatic wr_start(input logic [1:0] a, input logic [7:0] data);
    @(posedge clk); #1;
    bus.a = a; tb_d = data; tb_drv = 1'b1;
    bus.cs_n = 1'b0; bus.wr_n = 1'b0;
  endtask

  task automatic wr_rise(input int hold);
    repeat (hold) @(posedge clk);
    #1 bus.wr_n = 1'b1;
  endtask

  task automatic wr_tail();
    repeat (S + 3) @(posedge clk);
    #1 bus.cs_n = 1'b1; tb_drv = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] data);
    wr_start(a, data);
    wr_rise(3);
    wr_tail();
  endtask

  task automatic do_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    @(posedge clk); #1 bus.a = a;
    repeat (2) @(posedge clk);
    #1 bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    repeat (S + 2) @(posedge clk);
    push(K_D, exp, name);
    sample();
    bus.cs_n = 1'b1; bus.rd_n = 1'b1;
    repeat (S + 2) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; passed = 0; smp = 1'b0;
    reset_n = 1'b0; tb_d = 8'h00; tb_drv = 1'b0;
    bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.a = 2'd0;
    pa_in = 8'h5A; pb_in = 8'h3C; pc_in = 8'hA5;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    push(K_PA, 8'h00, "rst_pa_out"); push(K_PB, 8'h00, "rst_pb_out");
    push(K_PC, 8'h00, "rst_pc_out"); push(K_PAOE, 8'h00, "rst_pa_oe");
    push(K_PBOE, 8'h01, "rst_pb_oe"); push(K_PCOE, 8'h00, "rst_pc_oe");
    sample();

    total++;
    if (pb_oe === 1'b1) passed++;
    else $display("FAIL direct_rst_pb_oe: got %b expected 1", pb_oe);
    total++;
    if (pa_oe === 1'b0) passed++;
    else $display("FAIL direct_rst_pa_oe: got %b expected 0", pa_oe);

    do_read(2'd0, 8'h5A, "rd_a_pins");
    do_read(2'd3, 8'h99, "rd_ctrl_rst");
    do_read(2'd1, 8'h00, "rd_b_latch");
    do_read(2'd2, 8'hA5, "rd_c_pins");

    // Commit lands exactly S+1 clocks after the wr_n rise.
    wr_start(2'd1, 8'hC3);
    wr_rise(4);
    for (int k = 1; k <= S + 1; k++) begin
      push(K_PB, (k == S + 1) ? 8'hC3 : 8'h00, "wr_b_latency");
      sample();
    end
    wr_tail();
    do_read(2'd1, 8'hC3, "rd_b_written");

    // Long strobe: nothing happens while low, one commit on the rise.
    wr_start(2'd0, 8'h77);
    repeat (10) @(posedge clk);
    push(K_PA, 8'h00, "wr_a_hold_low");
    sample();
    wr_rise(10);
    wr_tail();
    push(K_PA, 8'h77, "wr_a_long");
    sample();
    do_read(2'd0, 8'h5A, "rd_a_input_dir");

    do_write(2'd1, 8'hFF);
    push(K_PB, 8'hFF, "wr_b_ff");
    sample();

    do_write(2'd3, 8'h80);
    push(K_PA, 8'h00, "mset_pa_clr"); push(K_PB, 8'h00, "mset_pb_clr");
    push(K_PC, 8'h00, "mset_pc_clr"); push(K_PAOE, 8'h01, "mset_pa_oe");
    push(K_PBOE, 8'h01, "mset_pb_oe"); push(K_PCOE, 8'hFF, "mset_pc_oe");
    sample();

    total++;
    if (pc_oe === 8'hFF) passed++;
    else $display("FAIL direct_mset_pc_oe: got %02h expected ff", pc_oe);
    total++;
    if (pa_out === 8'h00) passed++;
    else $display("FAIL direct_mset_pa_out: got %02h expected 00", pa_out);

    do_read(2'd2, 8'h00, "rd_c_latch");
    do_read(2'd3, 8'h80, "rd_ctrl_80");

    do_write(2'd2, 8'h0F);
    do_write(2'd3, 8'hE0);
    push(K_PC, 8'h0F, "mode1_ignored_pc");
    sample();
    do_read(2'd3, 8'h80, "mode1_ignored_ctrl");
    do_write(2'd3, 8'h84);
    push(K_PC, 8'h0F, "mode_b1_ignored_pc");
    sample();
    do_read(2'd3, 8'h80, "mode_b1_ignored_ctrl");

    do_write(2'd3, 8'h0B);
`ifdef PPI_PORTC_BSR_EN
    push(K_PC, 8'h2F, "bsr_set5");
`else
    push(K_PC, 8'h0F, "bsr_set5");
`endif
    sample();
    do_write(2'd3, 8'h0A);
    push(K_PC, 8'h0F, "bsr_clr5");
    sample();
    do_read(2'd3, 8'h80, "bsr_ctrl_kept");

    do_write(2'd3, 8'h90);
    push(K_PAOE, 8'h00, "m90_pa_oe"); push(K_PBOE, 8'h01, "m90_pb_oe");
    push(K_PCOE, 8'hFF, "m90_pc_oe");
    sample();

    // Snapshot read: pin change after the read starts is not seen.
    pa_in = 8'h11;
    @(posedge clk); #1 bus.a = 2'd0;
    repeat (3) @(posedge clk);
    #1 bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    repeat (S + 2) @(posedge clk);
    push(K_D, 8'h11, "snap_before");
    sample();
    pa_in = 8'h22;
    repeat (3) @(posedge clk);
    push(K_D, 8'h11, "snap_after1");
    sample();
    push(K_D, 8'h11, "snap_after2");
    sample();
    bus.cs_n = 1'b1; bus.rd_n = 1'b1;
    repeat (S + 2) @(posedge clk);
    do_read(2'd0, 8'h22, "rd_a_new");

    // Chip select released before the write strobe: no commit.
    wr_start(2'd1, 8'h55);
    repeat (4) @(posedge clk);
    #1 bus.cs_n = 1'b1;
    repeat (S + 2) @(posedge clk);
    #1 bus.wr_n = 1'b1;
    repeat (S + 4) @(posedge clk);
    #1 tb_drv = 1'b0;
    push(K_PB, 8'h00, "cs_early_no_commit");
    sample();

    // Read and write strobes together: write still commits.
    wr_start(2'd1, 8'h66);
    bus.rd_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    wr_tail();
    push(K_PB, 8'h66, "rd_wr_overlap");
    sample();

    // Reset during a write loses the strobe.
    wr_start(2'd1, 8'h99);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.wr_n = 1'b1; bus.cs_n = 1'b1; tb_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (S + 5) @(posedge clk);
    push(K_PB, 8'h00, "rst_mid_write_pb");
    push(K_PAOE, 8'h00, "rst_mid_write_paoe");
    sample();

    total++;
    if (pb_out === 8'h00) passed++;
    else $display("FAIL direct_rst_mid_write_pb: got %02h expected 00", pb_out);

    do_read(2'd3, 8'h99, "rst_mid_write_ctrl");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
